wb_merge: RTL and testbench

- Writeback-side consumer of the multiplier result interface (mul_wb_*). Also takes the single-cycle ALU result interface (alu_wb_*).
- Merges both onto the one register-file write port. The ALU has fixed priority.
- Multiplier results that lose arbitration are held in a small FIFO and drained in order. Queued results are killed if a younger ALU write targets the same register.
- Raises a stall toward issue before the FIFO can overflow.

---
 rtl/wb_merge_pkg.sv | 12 +
 rtl/wb_mul_fifo.sv | 74 +++++++
 rtl/wb_merge.sv | 91 +++++++++
 tb/tb_wb_merge.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/wb_merge_pkg.sv
// wb_merge_pkg: shared writeback widths, zero-register constant and the
// writeback entry layout used by the ALU/MUL (and later LSU) writeback paths.
package wb_merge_pkg;
    localparam int WB_DATA_W = 32;
    localparam int WB_REG_W  = 5;
    localparam logic [WB_REG_W-1:0] ZERO_REG = 5'd0;
    typedef struct packed {
        logic                 writereg;
        logic [WB_REG_W-1:0]  regdest;
        logic [WB_DATA_W-1:0] wbvalue;
    } wb_entry_t;
endpackage

// File: rtl/wb_mul_fifo.sv
// wb_mul_fifo: in-order queue of multiplier results awaiting the register-file
// write port, with per-entry kill when a younger ALU write hits the same register.
module wb_mul_fifo
    import wb_merge_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int REG_W  = WB_REG_W,
    parameter int DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [REG_W-1:0]       push_reg_i,
    input  logic [DATA_W-1:0]      push_val_i,
    input  logic                   pop_i,
    input  logic                   kill_i,
    input  logic [REG_W-1:0]       kill_reg_i,
    output logic                   head_we_o,
    output logic [REG_W-1:0]       head_reg_o,
    output logic [DATA_W-1:0]      head_val_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0]  we_q;
    logic [REG_W-1:0]  reg_q [DEPTH];
    logic [DATA_W-1:0] val_q [DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [PW:0]       count_q;
    logic [DEPTH-1:0]  kill_vec;
    logic              accept;

    always_comb begin
        kill_vec = '0;
        for (int i = 0; i < DEPTH; i++)
            kill_vec[i] = kill_i && (reg_q[i] == kill_reg_i);
    end

    // a full queue still takes a push when the head leaves in the same cycle
    assign accept     = push_i && (!full_o || pop_i);
    assign head_we_o  = we_q[rd_q];
    assign head_reg_o = reg_q[rd_q];
    assign head_val_o = val_q[rd_q];
    assign count_o    = count_q;
    assign empty_o    = count_q == '0;
    assign full_o     = count_q == (PW+1)'(DEPTH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            we_q <= we_q & ~kill_vec;
            if (accept) begin
                we_q[wr_q] <= !(kill_i && (push_reg_i == kill_reg_i));
                wr_q       <= wr_q + 1'b1;
            end
            if (pop_i)
                rd_q <= rd_q + 1'b1;
            count_q <= count_q + (PW+1)'(accept) - (PW+1)'(pop_i);
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            reg_q[wr_q] <= push_reg_i;
            val_q[wr_q] <= push_val_i;
        end
    end
endmodule

// File: rtl/wb_merge.sv
// wb_merge: merges ALU (priority) and queued multiplier results onto one
// register-file write port. Define WB_MUL_BYPASS_EN to let an idle-path mul skip the queue.
module wb_merge
    import wb_merge_pkg::*;
#(
    parameter int DATA_W      = WB_DATA_W,
    parameter int REG_W       = WB_REG_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int STALL_SLACK = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_wb_oper,
    input  logic              alu_wb_writereg,
    input  logic [REG_W-1:0]  alu_wb_regdest,
    input  logic [DATA_W-1:0] alu_wb_wbvalue,
    input  logic              mul_wb_oper,
    input  logic              mul_wb_writereg,
    input  logic [REG_W-1:0]  mul_wb_regdest,
    input  logic [DATA_W-1:0] mul_wb_wbvalue,
    output logic              wb_rf_writereg,
    output logic [REG_W-1:0]  wb_rf_regdest,
    output logic [DATA_W-1:0] wb_rf_wbvalue,
    output logic              wb_iss_mulstall,
    output logic              wb_overflow
);
    logic                         alu_wr, mul_wr, bypass, push, pop;
    logic                         head_we, empty, full;
    logic [REG_W-1:0]             head_reg;
    logic [DATA_W-1:0]            head_val;
    logic [$clog2(FIFO_DEPTH):0]  count;
    logic                         we_q, ovf_q;
    logic [REG_W-1:0]             reg_q;
    logic [DATA_W-1:0]            val_q;

    assign alu_wr = alu_wb_oper && alu_wb_writereg && (alu_wb_regdest != REG_W'(ZERO_REG));
    assign mul_wr = mul_wb_oper && mul_wb_writereg && (mul_wb_regdest != REG_W'(ZERO_REG));
`ifdef WB_MUL_BYPASS_EN
    assign bypass = mul_wr && empty && !alu_wr;
`else
    assign bypass = 1'b0;
`endif
    assign push = mul_wr && !bypass;
    assign pop  = !alu_wr && !empty;

    wb_mul_fifo #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push),
        .push_reg_i (mul_wb_regdest),
        .push_val_i (mul_wb_wbvalue),
        .pop_i      (pop),
        .kill_i     (alu_wr),
        .kill_reg_i (alu_wb_regdest),
        .head_we_o  (head_we),
        .head_reg_o (head_reg),
        .head_val_o (head_val),
        .count_o    (count),
        .empty_o    (empty),
        .full_o     (full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_q  <= 1'b0;
            reg_q <= '0;
            val_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            we_q <= alu_wr || bypass || (pop && head_we);
            if (alu_wr) begin
                reg_q <= alu_wb_regdest;
                val_q <= alu_wb_wbvalue;
            end else if (bypass) begin
                reg_q <= mul_wb_regdest;
                val_q <= mul_wb_wbvalue;
            end else if (pop) begin
                reg_q <= head_reg;
                val_q <= head_val;
            end
            if (push && full && !pop)
                ovf_q <= 1'b1;
        end
    end

    assign wb_rf_writereg  = we_q;
    assign wb_rf_regdest   = reg_q;
    assign wb_rf_wbvalue   = val_q;
    assign wb_overflow     = ovf_q;
    assign wb_iss_mulstall = int'(count) >= FIFO_DEPTH - STALL_SLACK;
endmodule

// File: tb/tb_wb_merge.sv
// tb_wb_merge: directed vectors for wb_merge; expected results are hand-computed
// from the arbitration, kill, fill/overflow and reset rules.
module tb_wb_merge;
    import wb_merge_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 alu_wb_oper, alu_wb_writereg, mul_wb_oper, mul_wb_writereg;
    logic [WB_REG_W-1:0]  alu_wb_regdest, mul_wb_regdest, wb_rf_regdest;
    logic [WB_DATA_W-1:0] alu_wb_wbvalue, mul_wb_wbvalue, wb_rf_wbvalue;
    logic                 wb_rf_writereg, wb_iss_mulstall, wb_overflow;
    int                   n_vec = 0;
    int                   n_err = 0;

    wb_merge dut (
        .clock           (clock),
        .reset           (reset),
        .alu_wb_oper     (alu_wb_oper),
        .alu_wb_writereg (alu_wb_writereg),
        .alu_wb_regdest  (alu_wb_regdest),
        .alu_wb_wbvalue  (alu_wb_wbvalue),
        .mul_wb_oper     (mul_wb_oper),
        .mul_wb_writereg (mul_wb_writereg),
        .mul_wb_regdest  (mul_wb_regdest),
        .mul_wb_wbvalue  (mul_wb_wbvalue),
        .wb_rf_writereg  (wb_rf_writereg),
        .wb_rf_regdest   (wb_rf_regdest),
        .wb_rf_wbvalue   (wb_rf_wbvalue),
        .wb_iss_mulstall (wb_iss_mulstall),
        .wb_overflow     (wb_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_wb(input string tag, input wb_entry_t e);
        check({tag, ".we"}, 64'(wb_rf_writereg), 64'(e.writereg));
        if (e.writereg) begin
            check({tag, ".reg"}, 64'(wb_rf_regdest), 64'(e.regdest));
            check({tag, ".val"}, 64'(wb_rf_wbvalue), 64'(e.wbvalue));
        end
    endtask

    task automatic check_count(input string tag, input int exp);
        check({tag, ".count"}, 64'(dut.u_fifo.count_q), 64'(exp));
    endtask

    task automatic drive(input logic ao, input logic [4:0] ar, input logic [31:0] av,
                         input logic mo, input logic [4:0] mr, input logic [31:0] mv);
        alu_wb_oper = ao; alu_wb_writereg = ao; alu_wb_regdest = ar; alu_wb_wbvalue = av;
        mul_wb_oper = mo; mul_wb_writereg = mo; mul_wb_regdest = mr; mul_wb_wbvalue = mv;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) step();
        expect_wb("rst", '{1'b0, 5'd0, 32'd0});
        check("rst.reg", 64'(wb_rf_regdest), 64'd0);
        check("rst.val", 64'(wb_rf_wbvalue), 64'd0);
        check("rst.stall", 64'(wb_iss_mulstall), 64'd0);
        check("rst.ovf", 64'(wb_overflow), 64'd0);
        check_count("rst", 0);
        reset = 1'b1;

        // multiplier alone
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hFFFF_FFFA);
        step();
        idle();
`ifdef WB_MUL_BYPASS_EN
        expect_wb("mul1.c1", '{1'b1, 5'd3, 32'hFFFF_FFFA});
        check_count("mul1.c1", 0);
        step();
        expect_wb("mul1.c2", '{1'b0, 5'd0, 32'd0});
`else
        expect_wb("mul1.c1", '{1'b0, 5'd0, 32'd0});
        check_count("mul1.c1", 1);
        step();
        expect_wb("mul1.c2", '{1'b1, 5'd3, 32'hFFFF_FFFA});
`endif
        check_count("mul1.end", 0);

        // ALU/mul conflict
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        step();
        idle();
        expect_wb("conf.c1", '{1'b1, 5'd1, 32'h11});
        check_count("conf.c1", 1);
        step();
        expect_wb("conf.c2", '{1'b1, 5'd2, 32'h22});
        check_count("conf.c2", 0);
        step();
        expect_wb("conf.c3", '{1'b0, 5'd0, 32'd0});

        // hazard kill
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd5, 32'hAAAA);
        step();
        drive(1'b1, 5'd5, 32'hBBBB, 1'b0, 5'd0, 32'd0);
        step();
        idle();
        expect_wb("kill.alu", '{1'b1, 5'd5, 32'hBBBB});
        check_count("kill.alu", 1);
        step();
        expect_wb("kill.pop", '{1'b0, 5'd0, 32'd0});
        check_count("kill.pop", 0);

        // fill, stall and overflow
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'd10, 32'h100 + i, 1'b1, (i == 5) ? 5'd6 : 5'(i), 32'h1000 + i);
            step();
            expect_wb($sformatf("fill%0d", i), '{1'b1, 5'd10, 32'h100 + i});
            check_count($sformatf("fill%0d", i), (i > 4) ? 4 : i);
            check($sformatf("fill%0d.stall", i), 64'(wb_iss_mulstall), 64'(i >= 2));
            check($sformatf("fill%0d.ovf", i), 64'(wb_overflow), 64'(i == 5));
        end
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            expect_wb($sformatf("drain%0d", i), '{1'b1, 5'(i), 32'h1000 + i});
            check($sformatf("drain%0d.stall", i), 64'(wb_iss_mulstall), 64'(i <= 2));
        end
        step();
        expect_wb("drain.end", '{1'b0, 5'd0, 32'd0});
        check("drain.ovf", 64'(wb_overflow), 64'd1);

        // register zero
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        step();
        expect_wb("r0.both", '{1'b0, 5'd0, 32'd0});
        check_count("r0.both", 0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
        step();
        idle();
        expect_wb("r0.mul", '{1'b0, 5'd0, 32'd0});
        check_count("r0.mul", 0);
        step();
        expect_wb("r0.after", '{1'b0, 5'd0, 32'd0});

        // asynchronous reset with entries queued
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'd11, 32'h200 + i, 1'b1, 5'(i), 32'h300 + i);
            step();
        end
        expect_wb("pre_rst", '{1'b1, 5'd11, 32'h203});
        check_count("pre_rst", 3);
        idle();
        #2 reset = 1'b0;
        #1;
        expect_wb("arst", '{1'b0, 5'd0, 32'd0});
        check("arst.reg", 64'(wb_rf_regdest), 64'd0);
        check("arst.val", 64'(wb_rf_wbvalue), 64'd0);
        check("arst.ovf", 64'(wb_overflow), 64'd0);
        check("arst.stall", 64'(wb_iss_mulstall), 64'd0);
        check_count("arst", 0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_wb($sformatf("post_rst%0d", i), '{1'b0, 5'd0, 32'd0});
        end
        check_count("post_rst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
